// File: rtl/two_power_mod.sv
// Iterative modular doubler: result = (a * 2^k) mod n, one conditional-subtract
// doubling per clock, with valid/ready handshakes on both sides.
module two_power_mod #(
  parameter int WIDTH     = 256,
  parameter int CNT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_n,
  input  logic [CNT_WIDTH-1:0] i_k,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [WIDTH-1:0]     o_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     x_q, x_d;
  logic [WIDTH-1:0]     n_q, n_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  // Doubling is one bit wider so the carry survives when n > 2^(WIDTH-1);
  // since x < n, a single subtract brings d back below n.
  logic [WIDTH:0]       dbl;
  logic                 dbl_ge_n;
  logic [WIDTH-1:0]     dbl_red;

  assign dbl      = {x_q, 1'b0};
  assign dbl_ge_n = (dbl >= {1'b0, n_q});
  assign dbl_red  = dbl_ge_n ? (dbl[WIDTH-1:0] - n_q) : dbl[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    n_d     = n_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          x_d     = i_a;
          n_d     = i_n;
          count_d = i_k;
          state_d = (i_k != '0) ? CALC : DONE;
        end
      end
      CALC: begin
        x_d     = dbl_red;
        count_d = count_q - CNT_WIDTH'(1);
        // Treat a zero count as final too, so a corrupted count cannot wrap.
        if (count_q <= CNT_WIDTH'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (o_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      n_q     <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      n_q     <= n_d;
      count_q <= count_d;
    end
  end

  assign i_ready  = (state_q == IDLE);
  assign o_valid  = (state_q == DONE);
  assign o_result = x_q;

endmodule
